// File: rtl/risc_pkg.sv
// Shared encodings for the 8-bit RISC lab CPU controller: opcode and phase
// constants plus the ALU-class opcode helper.
package risc_pkg;

  localparam int OP_W = 3;
  localparam int PH_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PH_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Control bundle between the sequencer and the CPU datapath/memory.
// master = controller side, slave = datapath side.
interface risc_controller_if;
  import risc_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            zero;
  logic [PH_W-1:0] phase;
  logic            sel;
  logic            rd;
  logic            wr;
  logic            ld_ir;
  logic            ld_ac;
  logic            ld_pc;
  logic            inc_pc;
  logic            data_e;
  logic            halt;

  modport master (
    input  opcode, zero,
    output phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );

endinterface

// File: rtl/risc_controller_phase_counter.sv
// Free-running 3-bit instruction phase counter with enable; wraps 7 -> 0.
module phase_counter
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PH_W-1:0] count
);

  logic [PH_W-1:0] r_count;

  // Advance one phase per enabled cycle; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/risc_controller.sv
// Instruction-cycle sequencer: an 8-phase counter plus a halted flag, with
// all control strobes decoded combinationally from phase/halted/opcode/zero.
module risc_controller
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  risc_controller_if.master bus
);

  logic [PH_W-1:0] w_count;
  phase_e          w_phase;
  opcode_e         w_op;
  logic            r_halted;
  logic            w_halted_next;
  logic            w_en;

  assign w_phase = phase_e'(w_count);
  assign w_op    = opcode_e'(bus.opcode);

  // The phase freezes on the very edge that enters the halted state,
  // so the halted machine sits in OP_ADDR.
  assign w_en = !w_halted_next;

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (w_en),
    .count (w_count)
  );

  // Next halted value: sticky once set; only entered from OP_ADDR on HLT.
  // The phase term gates the opcode so X in phases 0-3 cannot leak in.
  always_comb begin
    w_halted_next = r_halted;
    if (!r_halted && (w_phase == PH_OP_ADDR) && (w_op == OP_HLT)) begin
      w_halted_next = 1'b1;
    end
  end

  // Halted flag register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= w_halted_next;
    end
  end

  // Strobe decode. Phases 0-3 never look at opcode/zero. rd stays high for
  // three cycles in fetch so the registered memory output is valid before
  // ld_ir/ld_ac sample it, and rd is low whenever data_e can be high.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (r_halted) begin
      bus.halt = 1'b1;
    end else begin
      case (w_phase)
        PH_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          bus.halt   = (w_op == OP_HLT);
          bus.inc_pc = (w_op != OP_HLT);
        end
        PH_OP_FETCH: begin
          bus.rd = is_aluop(w_op);
        end
        PH_ALU_OP: begin
          bus.rd     = is_aluop(w_op);
          bus.inc_pc = (w_op == OP_SKZ) && bus.zero;
          bus.ld_pc  = (w_op == OP_JMP);
          bus.data_e = (w_op == OP_STO);
        end
        PH_STORE: begin
          bus.rd     = is_aluop(w_op);
          bus.ld_ac  = is_aluop(w_op);
          bus.inc_pc = (w_op == OP_JMP);
          bus.ld_pc  = (w_op == OP_JMP);
          bus.wr     = (w_op == OP_STO);
          bus.data_e = (w_op == OP_STO);
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.phase = w_count;

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: a small CPU datapath and memory around the DUT
// run a program with random data; strobes are checked every cycle against a
// table model, and PC/AC/memory against an instruction-level model.
module tb_risc_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  risc_controller_if bus ();

  risc_controller u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    case (op)
      3'd2:    return a + d;
      3'd3:    return a & d;
      3'd4:    return a ^ d;
      default: return d;
    endcase
  endfunction

  // Strobe expectations from the phase table; order is
  // {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}.
  function automatic logic [8:0] exp_strobes(input int ph, input bit halted,
                                             input logic [2:0] op, input logic z);
    bit alu_c, hlt;
    logic [8:0] v;
    if (halted) return 9'b0_0000_0001;
    alu_c = op inside {3'd2, 3'd3, 3'd4, 3'd5};
    hlt   = (op == 3'd0);
    v[8] = (ph < 4);
    v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu_c);
    v[6] = (ph == 7) && (op == 3'd6);
    v[5] = (ph == 2) || (ph == 3);
    v[4] = (ph == 7) && alu_c;
    v[3] = (ph >= 6) && (op == 3'd7);
    v[2] = (ph == 4 && !hlt) || (ph == 6 && op == 3'd1 && z === 1'b1) || (ph == 7 && op == 3'd7);
    v[1] = (ph >= 6) && (op == 3'd6);
    v[0] = (ph == 4) && hlt;
    return v;
  endfunction

  // Datapath: PC, IR, AC, registered-read memory.
  logic [7:0] prog [0:31];
  logic [7:0] mem  [0:31];
  logic [4:0] pc;
  logic [7:0] ir, ac, dout;
  logic [4:0] addr;
  logic [7:0] data_bus;

  assign addr     = bus.sel ? pc : ir[4:0];
  assign data_bus = bus.data_e ? ac : 8'hzz;

  always @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      ac   <= '0;
      ir   <= '0;
      dout <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= prog[i];
    end else begin
      if (bus.rd) dout <= mem[addr];
      if (bus.ld_ir) ir <= dout;
      if (bus.ld_pc) pc <= ir[4:0];
      else if (bus.inc_pc) pc <= pc + 5'd1;
      if (bus.ld_ac) ac <= alu(ir[7:5], ac, dout);
      if (bus.wr) mem[addr] <= data_bus;
    end
  end

  // Cycle-level model state.
  int         m_ph     = 0;
  bit         m_halted = 1'b0;
  logic [2:0] m_op;
  logic       m_z;

  task automatic cycle_check();
    bit xm;
    xm   = m_halted || (m_ph < 4);
    m_op = ir[7:5];
    m_z  = (ac == 8'd0);
    bus.opcode = xm ? 3'bxxx : m_op;
    bus.zero   = xm ? 1'bx : m_z;
    #1;
    chk("phase", bus.phase, m_ph);
    chk("strobes", {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc,
                    bus.inc_pc, bus.data_e, bus.halt},
        exp_strobes(m_ph, m_halted, m_op, m_z));
    chk("inv_rd_data_e", bus.rd & bus.data_e, 0);
    chk("inv_wr_data_e", bus.wr & ~bus.data_e, 0);
    chk("inv_ldpc_ldac", bus.ld_pc & bus.ld_ac, 0);
    if (m_ph != 2 && m_ph != 3) chk("inv_inc_ldir", bus.inc_pc & bus.ld_ir, 0);
    $display("cyc phase=%0d halted=%0b op=%0d z=%0b pc=%0d ac=%02h",
             m_ph, m_halted, m_op, m_z, pc, ac);
    @(posedge clk);
    if (rst) begin
      m_ph = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_ph == 4 && m_op == 3'd0) m_halted = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    @(negedge clk);
  endtask

  // Instruction-level expectations.
  logic [4:0] q_pc [$];
  logic [7:0] q_ac [$];
  logic [7:0] isa_mem [0:31];
  logic [4:0] halt_pc;

  initial begin
    logic [4:0] ipc;
    logic [7:0] iac, ins;
    int ph_before;
    int cyc;

    bus.opcode = 3'bxxx;
    bus.zero   = 1'bx;

    // Program with randomized data and ALU ops.
    for (int i = 0; i < 32; i++) prog[i] = 8'($urandom_range(0, 255));
    prog[0]  = {3'd5, 5'd20};
    prog[1]  = {3'($urandom_range(2, 4)), 5'd21};
    prog[2]  = {3'd6, 5'd22};
    prog[3]  = {3'($urandom_range(2, 4)), 5'd23};
    prog[4]  = {3'($urandom_range(2, 4)), 5'd24};
    prog[5]  = {3'd5, 5'd25};
    prog[6]  = {3'd1, 5'd0};
    prog[7]  = {3'd0, 5'd0};
    prog[8]  = {3'd5, 5'd20};
    prog[9]  = {3'd1, 5'd0};
    prog[10] = {3'd7, 5'd12};
    prog[11] = {3'd0, 5'd0};
    prog[12] = {3'd6, 5'd26};
    prog[13] = {3'd0, 5'd0};
    prog[20] = 8'($urandom_range(1, 255));
    prog[25] = 8'd0;

    // Instruction-level reference run.
    for (int i = 0; i < 32; i++) isa_mem[i] = prog[i];
    ipc = '0;
    iac = '0;
    halt_pc = '0;
    for (int s = 0; s < 64; s++) begin
      ins = isa_mem[ipc];
      if (ins[7:5] == 3'd0) begin
        halt_pc = ipc;
        break;
      end
      ipc = ipc + 5'd1;
      case (ins[7:5])
        3'd1:    if (iac == 8'd0) ipc = ipc + 5'd1;
        3'd6:    isa_mem[ins[4:0]] = iac;
        3'd7:    ipc = ins[4:0];
        default: iac = alu(ins[7:5], iac, isa_mem[ins[4:0]]);
      endcase
      q_pc.push_back(ipc);
      q_ac.push_back(iac);
    end

    // Reset held two cycles with X on opcode/zero.
    @(posedge clk);
    @(negedge clk);
    cycle_check();
    rst = 1'b0;

    // Run the program until halt, within a cycle budget.
    cyc = 0;
    while (!m_halted && cyc < 400) begin
      ph_before = m_ph;
      cycle_check();
      cyc++;
      if (ph_before == 7 && m_ph == 0) begin
        if (q_pc.size() == 0) begin
          chk("extra_instr", 1, 0);
        end else begin
          chk("pc_after_instr", pc, q_pc.pop_front());
          chk("ac_after_instr", ac, q_ac.pop_front());
        end
      end
    end
    chk("halt_reached", bus.halt, 1);
    chk("instr_count", q_pc.size(), 0);

    // Ten cycles frozen in the halted state.
    for (int i = 0; i < 10; i++) cycle_check();
    chk("halt_pc", pc, halt_pc);
    chk("mem22", mem[22], isa_mem[22]);
    chk("mem26", mem[26], isa_mem[26]);
    chk("mem23", mem[23], isa_mem[23]);

    // One-cycle reset out of halt, then normal sequencing.
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    chk("reset_phase", bus.phase, 0);
    chk("reset_halt", bus.halt, 0);
    for (int i = 0; i < 12; i++) cycle_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
